instruction_fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS pipeline, directly upstream of the IF/ID buffer. It owns the program counter and drives a request/ready handshake to instruction memory. It presents each fetched instruction and its PC+4 to the IF/ID buffer, and accepts stalls from the hazard unit and redirects from branch/jump resolution. In-flight memory responses that a redirect makes stale are discarded, never forwarded.

---
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, handshakes with instruction memory,
// and feeds IF/ID. Optional misaligned-redirect trap under `FETCH_ALIGN_CHECK_EN`.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        PCWrite,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ready,
    input  logic [31:0] IMem_RData,
    output logic [31:0] Instruction,
    output logic [31:0] PC_Next,
    output logic        Fetch_Valid,
    output logic        Fetch_Exception
);

    typedef enum logic [1:0] {FETCH = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_load, pc_plus4;
    logic [31:0] pending_pc, pending_load;
    logic [31:0] hold_instr, hold_load;
    logic [31:0] target;
    logic [31:0] instr_sel;
    logic        req, valid;

    assign pc_plus4 = pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    logic exc_pulse;

    // A misaligned target is replaced by the trap vector on every redirect path.
    assign misaligned = Redirect_PC[1:0] != 2'b00;
    assign target     = misaligned ? EXC_VECTOR : Redirect_PC;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) exc_pulse <= 1'b0;
        else        exc_pulse <= Redirect & misaligned;
    end

    assign Fetch_Exception = exc_pulse;
`else
    logic unused_cfg;

    assign target          = {Redirect_PC[31:2], 2'b00};
    assign Fetch_Exception = 1'b0;
    assign unused_cfg      = ^{EXC_VECTOR, Redirect_PC[1:0]};
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: begin
                if (Redirect)                    state_next = IMem_Ready ? FETCH : DRAIN;
                else if (IMem_Ready && !PCWrite) state_next = HOLD;
            end
            DRAIN:   if (IMem_Ready)           state_next = FETCH;
            HOLD:    if (Redirect || PCWrite)  state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        req       = 1'b0;
        valid     = 1'b0;
        instr_sel = IMem_RData;
        unique case (state)
            FETCH: begin
                req   = 1'b1;
                valid = IMem_Ready & ~Redirect;
            end
            DRAIN: req = 1'b1;
            HOLD: begin
                valid     = ~Redirect;
                instr_sel = hold_instr;
            end
            default: ;
        endcase
    end

    // Reset gates the handshake combinationally so an abandoned request drops at once.
    assign IMem_Req    = req & Rst_n;
    assign Fetch_Valid = valid & Rst_n;
    assign IMem_Addr   = pc;
    assign PC_Next     = pc_plus4;
    assign Instruction = Fetch_Valid ? instr_sel : 32'h0000_0000;

    always_comb begin
        pc_load      = pc;
        pending_load = pending_pc;
        hold_load    = hold_instr;
        unique case (state)
            FETCH: begin
                if (Redirect) begin
                    // Without a response the request must finish at the old address.
                    if (IMem_Ready) pc_load      = target;
                    else            pending_load = target;
                end else if (IMem_Ready) begin
                    if (PCWrite) pc_load   = pc_plus4;
                    else         hold_load = IMem_RData;
                end
            end
            DRAIN: begin
                if (Redirect)   pending_load = target;
                if (IMem_Ready) pc_load      = Redirect ? target : pending_pc;
            end
            HOLD: begin
                if (Redirect)     pc_load = target;
                else if (PCWrite) pc_load = pc_plus4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc         <= RESET_PC;
            pending_pc <= 32'h0000_0000;
            hold_instr <= 32'h0000_0000;
        end else begin
            pc         <= pc_load;
            pending_pc <= pending_load;
            hold_instr <= hold_load;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, streaming, stall, drain,
// redirect priority, misaligned target, PC wrap and asynchronous reset.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        PCWrite;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ready;
    logic [31:0] IMem_RData;
    logic [31:0] Instruction;
    logic [31:0] PC_Next;
    logic        Fetch_Valid;
    logic        Fetch_Exception;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit dut (
        .Clk(Clk), .Rst_n(Rst_n), .PCWrite(PCWrite), .Redirect(Redirect),
        .Redirect_PC(Redirect_PC), .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
        .IMem_Ready(IMem_Ready), .IMem_RData(IMem_RData), .Instruction(Instruction),
        .PC_Next(PC_Next), .Fetch_Valid(Fetch_Valid), .Fetch_Exception(Fetch_Exception)
    );

    always #5 Clk = ~Clk;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        Rst_n = 1'b0; PCWrite = 1'b1; Redirect = 1'b0; Redirect_PC = 32'h0;
        IMem_Ready = 1'b0; IMem_RData = 32'h0;
        tick();
        tick();
        Rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        Rst_n = 1'b0; PCWrite = 1'b1; Redirect = 1'b0; Redirect_PC = 32'h0;
        IMem_Ready = 1'b1; IMem_RData = 32'hFFFF_FFFF;
        tick();
        n_checks++; if (IMem_Req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", IMem_Req); end
        n_checks++; if (IMem_Addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h exp 00000000", IMem_Addr); end
        n_checks++; if (Instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h exp 00000000", Instruction); end
        n_checks++; if (PC_Next !== 32'h4) begin n_fail++; $display("FAIL reset_pcnext: got %h exp 00000004", PC_Next); end
        n_checks++; if (Fetch_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", Fetch_Valid); end
        n_checks++; if (Fetch_Exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b exp 0", Fetch_Exception); end
        tick();
        Rst_n = 1'b1;
        #1;
        n_checks++; if (IMem_Req !== 1'b1) begin n_fail++; $display("FAIL release_req: got %b exp 1", IMem_Req); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset();
        IMem_Ready = 1'b1; PCWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IMem_RData = 32'h1000_0000 | exp_addr[i];
            #1;
            n_checks++; if (IMem_Addr !== exp_addr[i]) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h exp %h", i, IMem_Addr, exp_addr[i]); end
            n_checks++; if (PC_Next !== exp_addr[i] + 32'd4) begin n_fail++; $display("FAIL stream_pcnext[%0d]: got %h exp %h", i, PC_Next, exp_addr[i] + 32'd4); end
            n_checks++; if (Fetch_Valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b exp 1", i, Fetch_Valid); end
            n_checks++; if (Instruction !== (32'h1000_0000 | exp_addr[i])) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h", i, Instruction); end
            tick();
        end
    endtask

    task automatic test_stall;
        do_reset();
        IMem_Ready = 1'b1; PCWrite = 1'b1; IMem_RData = 32'h1111_1111;
        tick();
        tick();
        IMem_RData = 32'hAABB_CCDD; PCWrite = 1'b0;
        #1;
        n_checks++; if (Instruction !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL stall_first_instr: got %h exp aabbccdd", Instruction); end
        tick();
        IMem_RData = 32'h5555_5555;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (IMem_Req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d]: got %b exp 0", i, IMem_Req); end
            n_checks++; if (Instruction !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL hold_instr[%0d]: got %h exp aabbccdd", i, Instruction); end
            n_checks++; if (IMem_Addr !== 32'h8) begin n_fail++; $display("FAIL hold_pc[%0d]: got %h exp 00000008", i, IMem_Addr); end
            n_checks++; if (PC_Next !== 32'hC) begin n_fail++; $display("FAIL hold_pcnext[%0d]: got %h exp 0000000c", i, PC_Next); end
            tick();
        end
        PCWrite = 1'b1;
        #1;
        n_checks++; if (Fetch_Valid !== 1'b1) begin n_fail++; $display("FAIL hold_release_valid: got %b exp 1", Fetch_Valid); end
        tick();
        n_checks++; if (IMem_Addr !== 32'hC || IMem_Req !== 1'b1) begin n_fail++; $display("FAIL after_hold: addr %h req %b exp 0000000c 1", IMem_Addr, IMem_Req); end
    endtask

    task automatic test_drain;
        do_reset();
        IMem_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h100;
        #1;
        n_checks++; if (Fetch_Valid !== 1'b0) begin n_fail++; $display("FAIL drain_enter_valid: got %b exp 0", Fetch_Valid); end
        tick();
        Redirect = 1'b0;
        #1;
        n_checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0) begin n_fail++; $display("FAIL drain_wait: req %b addr %h exp 1 00000000", IMem_Req, IMem_Addr); end
        tick();
        IMem_Ready = 1'b1; IMem_RData = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (Fetch_Valid !== 1'b0 || Instruction !== 32'h0) begin n_fail++; $display("FAIL drain_drop: valid %b instr %h exp 0 00000000", Fetch_Valid, Instruction); end
        tick();
        IMem_RData = 32'h1234_5678;
        #1;
        n_checks++; if (IMem_Addr !== 32'h100 || Fetch_Valid !== 1'b1) begin n_fail++; $display("FAIL drain_exit: addr %h valid %b exp 00000100 1", IMem_Addr, Fetch_Valid); end
        // Later redirects in DRAIN replace the pending target; a same-cycle one wins.
        do_reset();
        IMem_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h200;
        tick();
        Redirect_PC = 32'h240;
        tick();
        Redirect = 1'b0;
        tick();
        IMem_Ready = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h300;
        tick();
        Redirect = 1'b0;
        #1;
        n_checks++; if (IMem_Addr !== 32'h300) begin n_fail++; $display("FAIL drain_last_wins: got %h exp 00000300", IMem_Addr); end
        do_reset();
        IMem_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h200;
        tick();
        Redirect_PC = 32'h240;
        tick();
        Redirect = 1'b0; IMem_Ready = 1'b1;
        tick();
        n_checks++; if (IMem_Addr !== 32'h240) begin n_fail++; $display("FAIL drain_pending: got %h exp 00000240", IMem_Addr); end
    endtask

    task automatic test_redirect_zero_wait;
        do_reset();
        IMem_Ready = 1'b1; PCWrite = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h40;
        #1;
        n_checks++; if (Fetch_Valid !== 1'b0) begin n_fail++; $display("FAIL zw_redirect_valid: got %b exp 0", Fetch_Valid); end
        tick();
        Redirect = 1'b0;
        #1;
        n_checks++; if (IMem_Addr !== 32'h40 || Fetch_Valid !== 1'b1) begin n_fail++; $display("FAIL zw_redirect_next: addr %h valid %b exp 00000040 1", IMem_Addr, Fetch_Valid); end
    endtask

    task automatic test_hold_redirect;
        do_reset();
        IMem_Ready = 1'b1; PCWrite = 1'b0; IMem_RData = 32'hCAFE_0001;
        tick();
        PCWrite = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h400;
        #1;
        n_checks++; if (Fetch_Valid !== 1'b0 || Instruction !== 32'h0) begin n_fail++; $display("FAIL hold_redir_valid: valid %b instr %h exp 0 00000000", Fetch_Valid, Instruction); end
        tick();
        Redirect = 1'b0;
        #1;
        n_checks++; if (IMem_Addr !== 32'h400 || IMem_Req !== 1'b1) begin n_fail++; $display("FAIL hold_redir_pc: addr %h req %b exp 00000400 1", IMem_Addr, IMem_Req); end
    endtask

    task automatic test_misaligned;
        logic [31:0] exp_pc;
        logic        exp_exc;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_pc = 32'h80; exp_exc = 1'b1;
`else
        exp_pc = 32'h100; exp_exc = 1'b0;
`endif
        do_reset();
        IMem_Ready = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h102;
        tick();
        Redirect = 1'b0;
        #1;
        n_checks++; if (IMem_Addr !== exp_pc) begin n_fail++; $display("FAIL misaligned_pc: got %h exp %h", IMem_Addr, exp_pc); end
        n_checks++; if (Fetch_Exception !== exp_exc) begin n_fail++; $display("FAIL misaligned_exc: got %b exp %b", Fetch_Exception, exp_exc); end
        tick();
        n_checks++; if (Fetch_Exception !== 1'b0) begin n_fail++; $display("FAIL misaligned_exc_clear: got %b exp 0", Fetch_Exception); end
    endtask

    task automatic test_wrap;
        do_reset();
        IMem_Ready = 1'b1; Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFC;
        tick();
        Redirect = 1'b0;
        #1;
        n_checks++; if (PC_Next !== 32'h0) begin n_fail++; $display("FAIL wrap_pcnext: got %h exp 00000000", PC_Next); end
        tick();
        n_checks++; if (IMem_Addr !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h exp 00000000", IMem_Addr); end
    endtask

    task automatic test_async_reset;
        do_reset();
        IMem_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h100;
        tick();
        Redirect = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        n_checks++; if (IMem_Req !== 1'b0 || IMem_Addr !== 32'h0) begin n_fail++; $display("FAIL async_reset: req %b addr %h exp 0 00000000", IMem_Req, IMem_Addr); end
        tick();
        Rst_n = 1'b1; IMem_Ready = 1'b1; IMem_RData = 32'h0BAD_F00D;
        #1;
        n_checks++; if (IMem_Addr !== 32'h0 || Fetch_Valid !== 1'b1) begin n_fail++; $display("FAIL async_release: addr %h valid %b exp 00000000 1", IMem_Addr, Fetch_Valid); end
        tick();
        n_checks++; if (IMem_Addr !== 32'h4) begin n_fail++; $display("FAIL async_pending_ignored: got %h exp 00000004", IMem_Addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_drain();
        test_redirect_zero_wait();
        test_hold_redirect();
        test_misaligned();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
